tlb_op_ctrl: RTL
================

Name: tlb_op_ctrl

Overview:
- Sequencer for the shared TLB and its CP0 interface.
- Accepts one TLB maintenance op at a time (TLBP from EX; TLBR, TLBWI, TLBWR from WB) and drives the TLB search, read and write ports.
- Returns probe and read results to CP0. After any op that changes translation state, issues a refetch request to the front end.
- Maintains the CP0 Random counter used by TLBWR.

Parameters:
TLBNUM, 16, number of TLB entries (power of two, >=2)
IDXW, 4, index width = log2(TLBNUM)

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
op_valid  in  1  op request
op_ready  out  1  op accepted when op_valid & op_ready
op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_pc  in  32  PC of the TLB instruction
flush  in  1  WB exception/eret squash
entryhi_busy  in  1  mtc0 EntryHi in flight; blocks probe
c0_index  in  IDXW  CP0 Index.idx
c0_wired  in  IDXW  CP0 Wired
c0_entryhi  in  32  CP0 EntryHi (VPN2 [31:13], ASID [7:0])
s_vpn2  out  19  TLB search VPN2
s_asid  out  8  TLB search ASID
s_found  in  1  TLB search hit
s_index  in  IDXW  TLB search hit index
r_index  out  IDXW  TLB read index
we  out  1  TLB write enable
w_index  out  IDXW  TLB write index
probe_done  out  1  one-cycle pulse: probe result valid
probe_found  out  1  registered hit flag
probe_index  out  IDXW  registered hit index
read_done  out  1  one-cycle pulse: CP0 captures r_* fields
refetch_valid  out  1  refetch request
refetch_ready  in  1  front end accepts refetch
refetch_pc  out  32  op_pc + 4
random  out  IDXW  CP0 Random value

Behaviour:
- Reset: synchronous, active-high on reset; clock clk.
- Reset values: state IDLE; op_ready 0 during reset, 1 the cycle after; we, probe_done, read_done, refetch_valid, probe_found all 0; probe_index 0; refetch_pc 0; random TLBNUM-1.
- States: IDLE, WAIT_HI, PROBE, PDONE, READ, WRITE, REFETCH.
- op_ready = (state==IDLE) & !flush.
- Accept in cycle T latches op_code, op_pc, and w_index. w_index = c0_index for TLBWI, random for TLBWR.
- TLBP: goes to WAIT_HI if entryhi_busy, else PROBE.
  - WAIT_HI moves to PROBE on the first cycle entryhi_busy=0.
  - PROBE: s_vpn2/s_asid driven from c0_entryhi; probe_found/probe_index registered at the end of the cycle.
  - PDONE: probe_done=1 for one cycle, then IDLE. Unblocked latency is 2 cycles (probe_done in T+2).
  - On a miss, probe_index holds its previous value.
- TLBR: READ at T+1.
  - r_index = c0_index; read_done=1 that cycle.
  - Then REFETCH.
- TLBWI/TLBWR: WRITE at T+1.
  - we=1 for exactly one cycle with the latched w_index.
  - Then REFETCH.
- REFETCH: refetch_valid=1 and refetch_pc=op_pc+4 (mod 2^32), held stable until refetch_ready; then IDLE.
  - refetch_ready=1 on the first REFETCH cycle gives a single-cycle request.
- Flush:
  - In WAIT_HI or PROBE: return to IDLE; no probe_done.
  - In PDONE, READ, WRITE, REFETCH: ignored (op already committed).
  - flush in IDLE blocks acceptance.
- s_vpn2/s_asid always reflect c0_entryhi. r_index is always c0_index. we is asserted only in WRITE.
- Random counter:
  - Decrements by 1 every cycle.
  - When random <= c0_wired, or random==0, reloads TLBNUM-1 next cycle.
  - If c0_wired >= TLBNUM-1, it holds TLBNUM-1.
  - Not affected by flush.
- Reset mid-op drops the op with no write, pulse or refetch.

Optional Feature:
- Macro TLBWR_EN.
- Defined: TLBWR is supported as above; the Random counter is implemented.
- Undefined: the counter is removed and random is tied to TLBNUM-1. op_code 11 is accepted and treated exactly as TLBWI (w_index=c0_index).

Test Plan:
- TLBWI, c0_index=5, op_pc=0xBFC00100, refetch_ready=1 -> we=1 w_index=5 at T+1; refetch_valid at T+2 with refetch_pc=0xBFC00104; op_ready=1 at T+3.
- TLBP with entryhi_busy high for 3 cycles, TLB hit at index 9 -> no search result taken while busy; probe_done pulse with probe_found=1, probe_index=9 two cycles after busy drops.
- TLBP, flush asserted in PROBE cycle -> no probe_done; IDLE next cycle; new op accepted once flush=0.
- TLBR, c0_index=3 -> r_index=3 with read_done=1 at T+1; refetch_valid held 4 cycles while refetch_ready=0, pc unchanged.
- c0_wired=12, TLBNUM=16, free run from reset -> random sequence 15,14,13,12,15,14,...; TLBWR accepted when random=13 -> we at T+1 with w_index=13.
- TLBWR_EN undefined, op_code=11, c0_index=7 -> we with w_index=7; random constant 15.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_op_ctrl
//  Purpose  : Sequencer for the shared TLB and its CP0 interface. Runs one
//             TLB maintenance op at a time (TLBP, TLBR, TLBWI, TLBWR), drives
//             the TLB search/read/write ports, returns probe/read results to
//             CP0, requests a front-end refetch after state-changing ops and
//             maintains the CP0 Random counter.
//  Config   : TLBWR_EN - when defined, TLBWR writes at the Random index and
//             the Random counter is implemented. When undefined, Random is
//             tied to TLBNUM-1 and TLBWR behaves exactly like TLBWI.
//  Revision : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    // op request
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [1:0]      op_code,
    input  logic [31:0]     op_pc,
    input  logic            flush,
    input  logic            entryhi_busy,
    // CP0 state
    input  logic [IDXW-1:0] c0_index,
    input  logic [IDXW-1:0] c0_wired,
    input  logic [31:0]     c0_entryhi,
    // TLB search port
    output logic [18:0]     s_vpn2,
    output logic [7:0]      s_asid,
    input  logic            s_found,
    input  logic [IDXW-1:0] s_index,
    // TLB read port
    output logic [IDXW-1:0] r_index,
    // TLB write port
    output logic            we,
    output logic [IDXW-1:0] w_index,
    // results to CP0
    output logic            probe_done,
    output logic            probe_found,
    output logic [IDXW-1:0] probe_index,
    output logic            read_done,
    // refetch request to the front end
    output logic            refetch_valid,
    input  logic            refetch_ready,
    output logic [31:0]     refetch_pc,
    // CP0 Random
    output logic [IDXW-1:0] random
);

    localparam logic [IDXW-1:0] MAX_IDX = IDXW'(TLBNUM - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_HI = 3'd1;
    localparam logic [2:0] S_PROBE   = 3'd2;
    localparam logic [2:0] S_PDONE   = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_WRITE   = 3'd5;
    localparam logic [2:0] S_REFETCH = 3'd6;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic            accept;
    logic [IDXW-1:0] w_index_sel;
    logic [IDXW-1:0] w_index_reg;
    logic            unused_ok;

    // Reset is folded in so a request is never taken in a reset cycle.
    assign op_ready = (state == S_IDLE) & ~flush & ~reset;
    assign accept   = op_valid & op_ready;

    // The search and read ports follow CP0 directly; results are only
    // consumed in the states that need them.
    assign s_vpn2  = c0_entryhi[31:13];
    assign s_asid  = c0_entryhi[7:0];
    assign r_index = c0_index;

    // Side-effect outputs are suppressed during reset so that an op caught
    // mid-flight produces no write, pulse or refetch.
    assign we            = (state == S_WRITE)   & ~reset;
    assign probe_done    = (state == S_PDONE)   & ~reset;
    assign read_done     = (state == S_READ)    & ~reset;
    assign refetch_valid = (state == S_REFETCH) & ~reset;
    assign w_index       = w_index_reg;

`ifdef TLBWR_EN
    // Random walks down from TLBNUM-1 to Wired, then wraps back to the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            random <= MAX_IDX;
        end else if ((c0_wired >= MAX_IDX) || (random <= c0_wired) ||
                     (random == '0)) begin
            random <= MAX_IDX;
        end else begin
            random <= random - {{(IDXW-1){1'b0}}, 1'b1};
        end
    end

    assign w_index_sel = (op_code == OP_TLBWR) ? random : c0_index;
    assign unused_ok   = ^c0_entryhi[12:8];
`else
    assign random      = MAX_IDX;
    assign w_index_sel = c0_index;
    assign unused_ok   = ^{c0_entryhi[12:8], c0_wired};
`endif

    // Next-state selection for the op sequencer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_TLBP: state_next = entryhi_busy ? S_WAIT_HI : S_PROBE;
                        OP_TLBR: state_next = S_READ;
                        default: state_next = S_WRITE;
                    endcase
                end
            end
            S_WAIT_HI: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (!entryhi_busy) begin
                    state_next = S_PROBE;
                end
            end
            S_PROBE:   state_next = flush ? S_IDLE : S_PDONE;
            S_PDONE:   state_next = S_IDLE;
            S_READ:    state_next = S_REFETCH;
            S_WRITE:   state_next = S_REFETCH;
            S_REFETCH: state_next = refetch_ready ? S_IDLE : S_REFETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture write index and return PC when an op is accepted; both stay
    // stable for the rest of the op.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_index_reg <= '0;
            refetch_pc  <= '0;
        end else if (accept) begin
            w_index_reg <= w_index_sel;
            refetch_pc  <= op_pc + 32'd4;
        end
    end

    // Probe result capture; a miss keeps the last hit index, and a squashed
    // probe leaves the previous result untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            probe_found <= 1'b0;
            probe_index <= '0;
        end else if ((state == S_PROBE) && !flush) begin
            probe_found <= s_found;
            if (s_found) begin
                probe_index <= s_index;
            end
        end
    end

endmodule
`default_nettype wire
